nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs a wide two's-complement addition by driving one shared 4-bit carry-in adder nibble by nibble, least-significant nibble first, over consecutive clock cycles. It accepts operand pairs through a valid/ready handshake, propagates the carry in an internal register, and presents the full-width sum, carry-out and signed overflow through a second valid/ready handshake. It sits between a requester and the 4-bit adder datapath, trading latency for area.

## Interface
- NIBBLES, 4: number of 4-bit nibbles per operand; must be ≥ 2. W = 4*NIBBLES.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair; high only in IDLE.
- a  in  W  operand A, two's complement.
- b  in  W  operand B, two's complement.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result.
- sum  out  W  result, modulo 2^W.
- carryout  out  1  carry out of bit W-1.
- overflow  out  1  signed overflow of the W-bit operation.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high at an edge, latch a and b into operand registers, clear the carry register, set nibble index idx=0, and go to RUN.
- RUN: each cycle, feed nibble idx of A, nibble idx of B, and the carry register to the adder.
  - Write the 4-bit result into sum[4*idx+3:4*idx] and the adder carry-out into the carry register.
  - Increment idx.
  - When idx==NIBBLES-1, capture carryout = adder carry-out and overflow = (carry into bit 3 of that nibble) XOR (carry out of bit 3), then go to DONE.
- DONE: out_valid=1. sum, carryout and overflow stay stable. in_valid is ignored. If out_ready is high at an edge, go to IDLE.
- Arithmetic: results are modulo 2^W. Intermediate nibbles do not affect overflow.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, sum 0, carryout 0, overflow 0, carry register 0, idx 0.
- A reset in any state, including mid-RUN, abandons the operation. Partial sum bits are cleared and no result is produced.
- sum updates nibble by nibble during RUN. Consumers must sample it only while out_valid is high.

## Timing
- Accept edge e0 → out_valid rises at edge eNIBBLES (4 cycles for the default).
- Minimum initiation interval: NIBBLES+2 cycles (RUN×NIBBLES, DONE ≥1, IDLE 1).
- in_ready is decoded from state, with no combinational path from in_valid. out_valid is decoded from state.
- A new operand cannot be accepted in the same edge that DONE hands off. IDLE always lasts at least one cycle.
- reset has priority over both handshakes on the same edge.

## Configuration
- SUBTRACT_EN defined:
  - Adds input port sub (1 bit), latched on the accept edge.
  - sub=1 computes A−B: B nibbles are inverted at the adder input and the carry register is initialised to 1.
  - carryout means "no borrow". overflow is signed overflow of the subtraction.
- SUBTRACT_EN undefined: no sub port, and the carry register is always initialised to 0.

## Structure
- Shared package adder_pkg holds:
  - NIBBLE_W = 4.
  - The state encoding constants IDLE/RUN/DONE.
- One sub-module, adder4_cin: a combinational 4-bit ripple adder with ports (sum[3:0], carryout, carry3, a[3:0], b[3:0], cin), where carry3 is the carry into bit 3. It is instantiated once, and the nibble multiplexing stays in the controller.

## Test plan
All scenarios use NIBBLES=4.
- a=0x0000, b=0x0000 → sum 0x0000, carryout 0, overflow 0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 and busy=1 throughout.
- a=0x7FFF, b=0x0001 → sum 0x8000, carryout 0, overflow 1 (carry ripples through all nibbles).
- a=0xFFFF, b=0x0001 → sum 0x0000, carryout 1, overflow 0. Then a=0x8000, b=0x8000 → sum 0x0000, carryout 1, overflow 1.
- Backpressure: result 0x1234+0x4321, out_ready held low 5 cycles while in_valid is held high with new operands → sum 0x5555 stays stable, out_valid stays 1, in_ready stays 0, the new operands are not taken. After out_ready, IDLE for one cycle, then accept.
- Reset asserted after the 2nd RUN cycle of 0xFFFF+0x0001 → next cycle out_valid 0, sum 0x0000, in_ready 1. Subsequent 0x0F0F+0x00F1 → 0x1000, carryout 0, overflow 0.
- SUBTRACT_EN defined:
  - sub=1, a=0x0005, b=0x0007 → sum 0xFFFE, carryout 0, overflow 0.
  - sub=1, a=0x8000, b=0x0001 → sum 0x7FFF, carryout 1, overflow 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and sequencer state encoding.
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4_cin.sv
// Combinational 4-bit ripple adder; carry3 exposes the carry into the top bit for overflow detection.
module adder4_cin
  import adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carryout,
  output logic                carry3,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W:0] w_c;

  // Ripple chain: w_c[i] is the carry into bit i.
  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
    carry3   = w_c[NIBBLE_W-1];
    carryout = w_c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide two's-complement adder sequenced through one shared 4-bit adder, LS nibble first.
// Optional feature macro: SUBTRACT_EN (adds a 'sub' port selecting A-B).
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
`ifdef SUBTRACT_EN
  input  logic                    sub,
`endif
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    carryout,
  output logic                    overflow,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (NIBBLES < 2) begin : g_bad_nibbles
    $error("nibble_serial_adder_ctrl: NIBBLES must be at least 2");
  end

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_carryout;
  logic               r_overflow;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
`ifdef SUBTRACT_EN
  logic               r_sub;
`endif

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_co;
  logic                w_nib_c3;
  logic                w_cin_init;

  // Select the active nibble pair; subtraction feeds the inverted B nibble.
  always_comb begin
    w_a_nib = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    w_b_nib = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
`ifdef SUBTRACT_EN
    if (r_sub) begin
      w_b_nib = ~r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    end else begin
      w_b_nib = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
    end
    w_cin_init = sub;
`else
    w_cin_init = 1'b0;
`endif
  end

  adder4_cin u_adder (
    .sum      (w_nib_sum),
    .carryout (w_nib_co),
    .carry3   (w_nib_c3),
    .a        (w_a_nib),
    .b        (w_b_nib),
    .cin      (r_carry)
  );

  // Sequencer: accept in IDLE, one nibble per cycle in RUN, hold the result in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carryout  <= 1'b0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SUBTRACT_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= w_cin_init;
            r_idx      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef SUBTRACT_EN
            r_sub      <= sub;
`endif
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
          r_carry <= w_nib_co;
          r_idx   <= r_idx + IDX_W'(1);
          // Only the top nibble decides carry-out and signed overflow.
          if (r_idx == LAST_IDX) begin
            r_carryout  <= w_nib_co;
            r_overflow  <= w_nib_c3 ^ w_nib_co;
            r_idx       <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign carryout  = r_carryout;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4): vector table, corner sequences, random vs model.
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carryout;
  logic        overflow;
  logic        busy;
`ifdef SUBTRACT_EN
  logic        sub_i;
`endif

  int total = 0;
  int bad   = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SUBTRACT_EN
    .sub       (sub_i),
`endif
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vs;
    logic [15:0] es;
    logic        eco;
    logic        eov;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: wide arithmetic on integers, overflow from the signed range.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic ms);
    logic [16:0] full;
    int r;
    if (ms) begin
      full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
      r = int'($signed(ma)) - int'($signed(mb));
    end else begin
      full = {1'b0, ma} + {1'b0, mb};
      r = int'($signed(ma)) + int'($signed(mb));
    end
    return {full[16], (r > 32767 || r < -32768), full[15:0]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("in_ready before accept", 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
`ifdef SUBTRACT_EN
    sub_i = ts;
`else
    if (ts) $display("note: subtract vector skipped in add-only build");
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int lat);
    logic ok;
    ok  = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      step();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'd4);
    check({nm, " busy/in_ready during run"}, 32'(ok), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    accept(ta, tb_v, ts);
    wait_done(nm, lat);
    check({nm, " sum"}, 32'(sum), 32'(es));
    check({nm, " carryout"}, 32'(carryout), 32'(eco));
    check({nm, " overflow"}, 32'(overflow), 32'(eov));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    check({nm, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rs;
    int          lat;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
`ifdef SUBTRACT_EN
    sub_i = 1'b0;
`endif
    vecs.push_back('{"zero",      16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{"7fff+1",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{"ffff+1",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{"8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
`ifdef SUBTRACT_EN
    vecs.push_back('{"5-7",       16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{"8000-1",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    step(); step();
    reset = 1'b0;
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset sum",       32'(sum),       32'd0);
    check("reset carryout",  32'(carryout),  32'd0);
    check("reset overflow",  32'(overflow),  32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].es, vecs[i].eco, vecs[i].eov);

    // Backpressure: new operands offered while the result is held.
    accept(16'h1234, 16'h4321, 1'b0);
    wait_done("bp", lat);
    a = 16'hAAAA; b = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp sum stable", 32'(sum), 32'h5555);
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle busy", 32'(busy), 32'd0);
    step();
    in_valid = 1'b0;
    check("bp accepted busy", 32'(busy), 32'd1);
    wait_done("bp2", lat);
    check("bp2 sum", 32'(sum), 32'hBBBB);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset after the second RUN cycle abandons the operation.
    accept(16'hFFFF, 16'h0001, 1'b0);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst mid out_valid", 32'(out_valid), 32'd0);
    check("rst mid sum", 32'(sum), 32'd0);
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    check("rst mid busy", 32'(busy), 32'd0);
    run_op("after reset", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
`ifdef SUBTRACT_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      m = model(ra, rb, rs);
      run_op("random", ra, rb, rs, m[15:0], m[17], m[16]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
